psum_ofifo: RTL

Output-collection FIFO directly downstream of the gated MAC columns. It captures each column's `bw_psum`-bit partial sum whenever that column pulses its `fifo_wr`. Columns finish at skewed cycles, so the block holds their results until every column has at least one entry. It then presents one aligned row of `col` partial sums to the consumer (SFP / psum memory writeback).

---
 rtl/psum_ofifo_if.sv | 25 ++
 rtl/psum_ofifo.sv | 89 ++++++++
 2 files changed

// File: rtl/psum_ofifo_if.sv
// Handshake bundle between the MAC columns / consumer and psum_ofifo.
// Column c occupies bits [(c+1)*bw_psum-1 : c*bw_psum] of in and out.
interface psum_ofifo_if #(
   parameter int col     = 8,
   parameter int bw_psum = 20
);
   logic [col*bw_psum-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [col*bw_psum-1:0] out;
   logic                   out_vld;
   logic                   o_valid;
   logic                   o_full;
   logic                   overflow;

   modport master (
      output in, wr, rd,
      input  out, out_vld, o_valid, o_full, overflow
   );

   modport slave (
      input  in, wr, rd,
      output out, out_vld, o_valid, o_full, overflow
   );
endinterface

// File: rtl/psum_ofifo.sv
// Per-column partial-sum FIFOs with a shared read pointer; a row pops only
// once every column holds at least one entry.
module psum_ofifo #(
   parameter int col     = 8,
   parameter int bw_psum = 20,
   parameter int depth   = 8
) (
   input  logic          clk,
   input  logic          reset,
   psum_ofifo_if.slave   bus
);
   localparam int aw = $clog2(depth);
   localparam int pw = aw + 1;

   logic [pw-1:0]          wr_ptr_q [col];
   logic [pw-1:0]          wr_ptr_d [col];
   logic [pw-1:0]          rd_ptr_q, rd_ptr_d;
   logic [col*bw_psum-1:0] out_q, out_d;
   logic                   out_vld_q, out_vld_d;
   logic                   overflow_q, overflow_d;
   logic [bw_psum-1:0]     mem_q [col][depth];

   logic [col-1:0]         empty;
   logic [col-1:0]         full;
   logic [col-1:0]         wr_acc;
   logic [col*bw_psum-1:0] head;
   logic                   pop;

   assign pop = bus.rd & bus.o_valid;

   generate
      for (genvar gi = 0; gi < col; gi++) begin : g_col
         logic [pw-1:0] count;

         assign count      = wr_ptr_q[gi] - rd_ptr_q;
         assign empty[gi]  = (count == '0);
         assign full[gi]   = (count == pw'(depth));
         // A full column still accepts a write when the same edge frees a slot.
         assign wr_acc[gi] = bus.wr[gi] & (~full[gi] | pop);
         assign head[gi*bw_psum +: bw_psum] = mem_q[gi][rd_ptr_q[aw-1:0]];

         always_comb begin
            wr_ptr_d[gi] = wr_acc[gi] ? wr_ptr_q[gi] + pw'(1) : wr_ptr_q[gi];
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               wr_ptr_q[gi] <= '0;
            end else begin
               wr_ptr_q[gi] <= wr_ptr_d[gi];
            end
         end

         // Storage is never reset; the cleared pointers make stale data unreachable.
         always_ff @(posedge clk) begin
            if (reset && wr_acc[gi]) begin
               mem_q[gi][wr_ptr_q[gi][aw-1:0]] <= bus.in[gi*bw_psum +: bw_psum];
            end
         end
      end
   endgenerate

   always_comb begin
      rd_ptr_d   = pop ? rd_ptr_q + pw'(1) : rd_ptr_q;
      out_d      = pop ? head : out_q;
      out_vld_d  = pop;
      overflow_d = overflow_q | (|(bus.wr & full & ~{col{pop}}));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.out      = out_q;
   assign bus.out_vld  = out_vld_q;
   assign bus.o_valid  = &(~empty);
   assign bus.o_full   = |full;
   assign bus.overflow = overflow_q;
endmodule
